// File: rtl/hba_rr_arbiter.sv
// Four-slot round-robin arbiter for the HBA bus with registered one-hot grants.
// Defining HBA_ARB_WATCHDOG_EN adds a watchdog that revokes grants whose transfer is never acknowledged.
module hba_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic       hba_clk,
  input  logic       hba_reset,
  input  logic [3:0] hba_mrequest,
  input  logic       hba_select,
  input  logic       hba_xferack,
  output logic [3:0] hba_mgrant,
  output logic       arb_busy,
  output logic       hba_timeout,
  output logic [1:0] hba_timeout_master
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] gidx_q, gidx_d;
  logic [3:0] grant_q, grant_d;

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] pick_off;
  logic [1:0] pick_idx;
  logic [3:0] pick_onehot;
  logic       release_now;
  logic       wd_fire;

  // Rotate the requests so bit 0 is the slot rr_ptr points at; the lowest set bit wins.
  assign req_dbl = {hba_mrequest, hba_mrequest};
  assign req_rot = 4'(req_dbl >> rr_ptr_q);

  always_comb begin
    pick_off = '0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 2'(i);
    end
  end

  assign pick_idx = rr_ptr_q + pick_off;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == 2'(gi));
    end
  endgenerate

  assign release_now = !hba_mrequest[gidx_q] && !hba_select;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    if (state_q == ST_IDLE) begin
      grant_d = '0;
      if (|hba_mrequest) begin
        gidx_d  = pick_idx;
        grant_d = pick_onehot;
        state_d = ST_GRANT;
      end
    end else begin
      if (release_now || wd_fire) begin
        grant_d  = '0;
        rr_ptr_d = gidx_q + 2'd1;
        state_d  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
    end
  end

  assign hba_mgrant = grant_q;
  assign arb_busy   = (state_q == ST_GRANT);

`ifdef HBA_ARB_WATCHDOG_EN
  logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [1:0]           tmaster_q, tmaster_d;
  logic                 wd_inc;

  // An ack on the limit cycle suppresses the increment, so the ack wins over the timeout.
  assign wd_inc  = (state_q == ST_GRANT) && hba_select && !hba_xferack;
  assign wd_fire = wd_inc && (wd_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = wd_fire;
    tmaster_d = wd_fire ? gidx_q : tmaster_q;
    if (wd_inc && !wd_fire) begin
      wd_cnt_d = (wd_cnt_q == {CNT_WIDTH{1'b1}}) ? wd_cnt_q : wd_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      tmaster_q <= '0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      tmaster_q <= tmaster_d;
    end
  end

  assign hba_timeout        = timeout_q;
  assign hba_timeout_master = tmaster_q;
`else
  logic [CNT_WIDTH-1:0] wd_unused;

  assign wd_fire            = 1'b0;
  assign hba_timeout        = 1'b0;
  assign hba_timeout_master = 2'b00;
  assign wd_unused          = CNT_WIDTH'(TIMEOUT_CYCLES) ^ {CNT_WIDTH{hba_xferack}};
`endif

endmodule

// File: tb/tb_hba_rr_arbiter.sv
// Directed bench for hba_rr_arbiter: expected outputs are queued as each step is driven
// and popped/compared one time unit after the clock edge that produces them.
module tb_hba_rr_arbiter;

  logic       hba_clk = 1'b0;
  logic       hba_reset;
  logic [3:0] hba_mrequest;
  logic       hba_select;
  logic       hba_xferack;
  logic [3:0] hba_mgrant;
  logic       arb_busy;
  logic       hba_timeout;
  logic [1:0] hba_timeout_master;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] g;
    logic       to;
    logic [1:0] tm;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  logic [1:0] exp_tm = 2'd0;

  hba_rr_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
    .hba_clk            (hba_clk),
    .hba_reset          (hba_reset),
    .hba_mrequest       (hba_mrequest),
    .hba_select         (hba_select),
    .hba_xferack        (hba_xferack),
    .hba_mgrant         (hba_mgrant),
    .arb_busy           (arb_busy),
    .hba_timeout        (hba_timeout),
    .hba_timeout_master (hba_timeout_master)
  );

  always #5 hba_clk = ~hba_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "bench time limit");
  end

  task automatic expect_out(input logic [3:0] eg, input logic eto, input string tag);
    exp_t e;
    e.g  = eg;
    e.to = eto;
    e.tm = exp_tm;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string tag;
    logic  ebusy;
    e     = sb.pop_front();
    tag   = sb_tag.pop_front();
    ebusy = (e.g != 4'b0000);
    n_assert++;
    assert (hba_mgrant === e.g) else begin
      n_fail++;
      $error("FAIL %s grant: got %b required %b", tag, hba_mgrant, e.g);
    end
    n_assert++;
    assert (arb_busy === ebusy) else begin
      n_fail++;
      $error("FAIL %s busy: got %b required %b", tag, arb_busy, ebusy);
    end
    n_assert++;
    assert (hba_timeout === e.to) else begin
      n_fail++;
      $error("FAIL %s timeout: got %b required %b", tag, hba_timeout, e.to);
    end
    n_assert++;
    assert (hba_timeout_master === e.tm) else begin
      n_fail++;
      $error("FAIL %s timeout_master: got %0d required %0d", tag, hba_timeout_master, e.tm);
    end
    $display("step %-12s req=%b sel=%b ack=%b -> grant=%b busy=%b to=%b tm=%0d",
             tag, hba_mrequest, hba_select, hba_xferack, hba_mgrant, arb_busy,
             hba_timeout, hba_timeout_master);
  endtask

  // Drive one cycle of inputs and check the outputs produced by the following edge.
  task automatic step(input logic [3:0] req, input logic sel, input logic ack,
                      input logic [3:0] eg, input logic eto, input string tag);
    hba_mrequest = req;
    hba_select   = sel;
    hba_xferack  = ack;
    expect_out(eg, eto, tag);
    @(posedge hba_clk);
    #1;
    compare_out();
  endtask

  task automatic pulse_reset();
    #2;
    hba_reset = 1'b1;
    exp_tm    = 2'd0;
    #1;
    expect_out(4'b0000, 1'b0, "rst_async");
    compare_out();
    repeat (2) @(posedge hba_clk);
    #2;
    hba_reset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    hba_reset    = 1'b1;
    hba_mrequest = 4'b0000;
    hba_select   = 1'b0;
    hba_xferack  = 1'b0;
    repeat (2) @(posedge hba_clk);
    #1;
    expect_out(4'b0000, 1'b0, "reset");
    compare_out();
    #1;
    hba_reset = 1'b0;

    // Single master: grant follows one edge after the request and holds while requested.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "idle");
    for (int i = 0; i < 10; i++) step(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, "single_hold");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "single_rel");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "single_idle");

    // Restart from rr_ptr=0, then rotate through all four masters and wrap to master 0.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      step(4'b1111, 1'b0, 1'b0, g, 1'b0, "rr_grant");
      step(4'b1111, 1'b1, 1'b0, g, 1'b0, "rr_xfer1");
      step(4'b1111, 1'b1, 1'b0, g, 1'b0, "rr_xfer2");
      step(4'b1111, 1'b1, 1'b1, g, 1'b0, "rr_xfer3");
      step(4'b1111 & ~g, 1'b0, 1'b0, 4'b0000, 1'b0, "rr_gap");
    end

    // rr_ptr=1: master 2 keeps select after dropping its request; master 1 may not preempt.
    step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, "sel_grant");
    step(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, "sel_xfer");
    step(4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0, "sel_hold1");
    step(4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0, "sel_hold2");
    step(4'b0010, 1'b1, 1'b0, 4'b0100, 1'b0, "no_preempt");
    step(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, "sel_rel");
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "next_m1");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "m1_rel");

`ifdef HBA_ARB_WATCHDOG_EN
    // rr_ptr=2: master 1 stalls with select high and no ack; fires on the 8th stalled edge.
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "wd_grant");
    for (int i = 0; i < 7; i++) step(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, "wd_stall");
    exp_tm = 2'd1;
    step(4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, "wd_fire");
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "wd_regrant");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "wd_rel");
    // Ack on the limit cycle wins; the count restarts so a full 8 more stalls are needed.
    step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, "ack_grant");
    for (int i = 0; i < 7; i++) step(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, "ack_stall");
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, "ack_last");
    for (int i = 0; i < 7; i++) step(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, "ack_restall");
    exp_tm = 2'd2;
    step(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, "ack_fire");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "ack_idle");
`else
    // Without the watchdog a stalled grant is held indefinitely.
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, "hold_grant");
    for (int i = 0; i < 12; i++) step(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, "hold_stall");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "hold_rel");
`endif

    // Async reset mid-grant, then rr_ptr=0 picks master 1 from 0110.
    step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, "pre_rst");
    step(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, "pre_rst_xfer");
    hba_mrequest = 4'b0000;
    hba_select   = 1'b0;
    pulse_reset();
    step(4'b0110, 1'b0, 1'b0, 4'b0010, 1'b0, "post_rst");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "post_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
